vga_scan_generator: RTL and testbench

Raster timing source and output stage for the VGA path. Generates the pixel coordinates that the drawing objects and the object mux consume, receives the mux's registered 24-bit colour back after a fixed latency, and drives aligned, blank-gated colour plus sync and blank strobes to the DAC. It is the scan-side counterpart of the object mux: the mux writes a colour per coordinate, and this block issues coordinates and reads colours out to the pins.

---
 rtl/vga_scan_generator.sv | 122 ++++++++++++
 tb/tb_vga_scan_generator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: raster counters, sync/blank decode, and a latency-matched colour output stage.
// Revision: 1.0
`default_nettype none

module vga_scan_generator #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int RGB_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  frameCount,
  output logic        hSyncN,
  output logic        vSyncN,
  output logic        blankN,
  output logic [7:0]  redOut,
  output logic [7:0]  greenOut,
  output logic [7:0]  blueOut
);

  localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        h_end;
  logic        v_end;

  assign h_end  = (h_count == H_TOTAL - 11'd1);
  assign v_end  = (v_count == V_TOTAL - 11'd1);
  assign pixelX = h_count;
  assign pixelY = v_count;

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count      <= H_TOTAL - 11'd1;
      v_count      <= V_TOTAL - 11'd1;
      startOfFrame <= 1'b0;
      frameCount   <= 8'hFF;
    end else begin
      startOfFrame <= h_end && v_end;
      if (h_end) begin
        h_count <= 11'd0;
        if (v_end) begin
          v_count    <= 11'd0;
          frameCount <= frameCount + 8'd1;
        end else begin
          v_count <= v_count + 11'd1;
        end
      end else begin
        h_count <= h_count + 11'd1;
      end
    end
  end

  logic       active_now;
  logic       hsync_now;
  logic       vsync_now;
  logic [2:0] flags_now;

  assign active_now = (h_count < H_VIS) && (v_count < V_VIS);
  assign hsync_now  = (h_count >= HS_START) && (h_count < HS_END);
  assign vsync_now  = (v_count >= VS_START) && (v_count < VS_END);
  assign flags_now  = {active_now, hsync_now, vsync_now};

  // Flag delay line; its depth matches the object mux's colour latency.
  logic [RGB_LATENCY-1:0][2:0] flag_pipe;
  logic [2:0]                  flags_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_pipe <= '0;
    end else begin
      flag_pipe[0] <= flags_now;
      for (int i = 1; i < RGB_LATENCY; i++) begin
        flag_pipe[i] <= flag_pipe[i-1];
      end
    end
  end

  assign flags_dly = flag_pipe[RGB_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blankN   <= 1'b0;
      hSyncN   <= 1'b1;
      vSyncN   <= 1'b1;
      redOut   <= 8'h00;
      greenOut <= 8'h00;
      blueOut  <= 8'h00;
    end else begin
      blankN   <= flags_dly[2];
      hSyncN   <= ~flags_dly[1];
      vSyncN   <= ~flags_dly[0];
      redOut   <= flags_dly[2] ? redIn   : 8'h00;
      greenOut <= flags_dly[2] ? greenIn : 8'h00;
      blueOut  <= flags_dly[2] ? blueIn  : 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_generator.sv
// Directed bench: two reduced-timing instances (latency 1 and 2) and one default-timing instance.
`default_nettype none

module tb_vga_scan_generator;

  localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VA = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = 32, S_VT = 17, S_FRAME = 544;
  localparam int D_HT = 800, D_VT = 525, D_FRAME = 420000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  logic [10:0] a_px, a_py, b_px, b_py, d_px, d_py;
  logic        a_sof, b_sof, d_sof;
  logic [7:0]  a_fc, b_fc, d_fc;
  logic        a_hs, a_vs, a_bl, b_hs, b_vs, b_bl, d_hs, d_vs, d_bl;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b, d_r, d_g, d_b;
  logic [7:0]  a_mux, b_mux1, b_mux2, b_muxy1, b_muxy2;

  // Registered object-mux models: colour = coordinate low byte.
  always @(posedge clk) begin
    a_mux   <= a_px[7:0];
    b_mux1  <= b_px[7:0];
    b_mux2  <= b_mux1;
    b_muxy1 <= b_py[7:0];
    b_muxy2 <= b_muxy1;
  end

  vga_scan_generator #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .RGB_LATENCY(1)
  ) dut_a (
    .clk(clk), .reset(reset), .redIn(a_mux), .greenIn(8'h55), .blueIn(8'hFF),
    .pixelX(a_px), .pixelY(a_py), .startOfFrame(a_sof), .frameCount(a_fc),
    .hSyncN(a_hs), .vSyncN(a_vs), .blankN(a_bl),
    .redOut(a_r), .greenOut(a_g), .blueOut(a_b)
  );

  vga_scan_generator #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .RGB_LATENCY(2)
  ) dut_b (
    .clk(clk), .reset(reset), .redIn(b_mux2), .greenIn(8'hAA), .blueIn(b_muxy2),
    .pixelX(b_px), .pixelY(b_py), .startOfFrame(b_sof), .frameCount(b_fc),
    .hSyncN(b_hs), .vSyncN(b_vs), .blankN(b_bl),
    .redOut(b_r), .greenOut(b_g), .blueOut(b_b)
  );

  vga_scan_generator dut_d (
    .clk(clk), .reset(reset), .redIn(8'hAA), .greenIn(8'h55), .blueIn(8'hFF),
    .pixelX(d_px), .pixelY(d_py), .startOfFrame(d_sof), .frameCount(d_fc),
    .hSyncN(d_hs), .vSyncN(d_vs), .blankN(d_bl),
    .redOut(d_r), .greenOut(d_g), .blueOut(d_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference raster: position q (pixels since the first (0,0)); q<0 means still in reset state.
  function automatic void model(input int q, input int ht, input int vt, input int ha, input int va,
                                input int hs0, input int hs1, input int vs0, input int vs1,
                                output int h, output int v, output bit act, output bit hs, output bit vs);
    if (q < 0) begin
      h = 0; v = 0; act = 0; hs = 0; vs = 0;
    end else begin
      h   = q % ht;
      v   = (q / ht) % vt;
      act = (h < ha) && (v < va);
      hs  = (h >= hs0) && (h < hs1);
      vs  = (v >= vs0) && (v < vs1);
    end
  endfunction

  task automatic check_reset_state(input string sfx);
    chk({"a_px_", sfx}, 32'(a_px), S_HT - 1);
    chk({"a_py_", sfx}, 32'(a_py), S_VT - 1);
    chk({"a_sof_", sfx}, 32'(a_sof), 0);
    chk({"a_fc_", sfx}, 32'(a_fc), 32'hFF);
    chk({"a_sync_", sfx}, 32'({a_hs, a_vs, a_bl}), 32'b110);
    chk({"a_rgb_", sfx}, 32'({a_r, a_g, a_b}), 0);
    chk({"b_sync_", sfx}, 32'({b_hs, b_vs, b_bl}), 32'b110);
    chk({"b_rgb_", sfx}, 32'({b_r, b_g, b_b}), 0);
    chk({"d_px_", sfx}, 32'(d_px), D_HT - 1);
    chk({"d_py_", sfx}, 32'(d_py), D_VT - 1);
    chk({"d_sync_", sfx}, 32'({d_hs, d_vs, d_bl, d_sof}), 32'b1100);
    chk({"d_rgb_", sfx}, 32'({d_r, d_g, d_b}), 0);
  endtask

  // n = rising edges since reset release (edge 1 shows (0,0)).
  task automatic check_cycle(input int n);
    int h, v, pos;
    bit act, hs, vs;
    pos = n - 1;
    model(pos, S_HT, S_VT, S_HA, S_VA, 20, 26, 12, 14, h, v, act, hs, vs);
    chk("a_px", 32'(a_px), h);
    chk("a_py", 32'(a_py), v);
    chk("a_sof", 32'(a_sof), (pos % S_FRAME) == 0);
    chk("a_fc", 32'(a_fc), (pos / S_FRAME) % 256);
    chk("b_pos", 32'({b_px, b_py, b_sof}), 32'({11'(h), 11'(v), (pos % S_FRAME) == 0}));
    chk("b_fc", 32'(b_fc), (pos / S_FRAME) % 256);
    model(n - 3, S_HT, S_VT, S_HA, S_VA, 20, 26, 12, 14, h, v, act, hs, vs);
    chk("a_flags", 32'({a_bl, a_hs, a_vs}), 32'({act, !hs, !vs}));
    chk("a_red", 32'(a_r), act ? (h & 255) : 0);
    chk("a_gb", 32'({a_g, a_b}), act ? 32'h55FF : 0);
    model(n - 4, S_HT, S_VT, S_HA, S_VA, 20, 26, 12, 14, h, v, act, hs, vs);
    chk("b_flags", 32'({b_bl, b_hs, b_vs}), 32'({act, !hs, !vs}));
    chk("b_red", 32'(b_r), act ? (h & 255) : 0);
    chk("b_green", 32'(b_g), act ? 32'hAA : 0);
    chk("b_blue", 32'(b_b), act ? (v & 255) : 0);
    model(pos, D_HT, D_VT, 640, 480, 656, 752, 490, 492, h, v, act, hs, vs);
    chk("d_pos", 32'({d_px, d_py}), 32'({11'(h), 11'(v)}));
    chk("d_sof_fc", 32'({d_sof, d_fc}), 32'({(pos % D_FRAME) == 0, 8'(pos / D_FRAME)}));
    model(n - 3, D_HT, D_VT, 640, 480, 656, 752, 490, 492, h, v, act, hs, vs);
    chk("d_flags", 32'({d_bl, d_hs, d_vs}), 32'({act, !hs, !vs}));
    chk("d_rgb", 32'({d_r, d_g, d_b}), act ? 32'hAA55FF : 0);
  endtask

  initial begin
    int d_hs_low, d_blank_hi, d_hs_first, a_vs_low, a_sof_cnt;
    d_hs_low = 0; d_blank_hi = 0; d_hs_first = -1; a_vs_low = 0; a_sof_cnt = 0;

    repeat (3) @(posedge clk);
    #1 check_reset_state("rst");

    @(negedge clk) reset = 1'b0;
    for (int n = 1; n <= 1200; n++) begin
      @(posedge clk);
      #1;
      check_cycle(n);
      if (n >= 3 && n <= 802) begin
        if (!d_hs) d_hs_low++;
        if (d_bl) d_blank_hi++;
        if (!d_hs && d_hs_first < 0) d_hs_first = n;
      end
      if (n >= 3 && n <= 546 && !a_vs) a_vs_low++;
      if (a_sof) a_sof_cnt++;
    end
    chk("d_hsync_width", d_hs_low, 96);
    chk("d_blank_width", d_blank_hi, 640);
    chk("d_hsync_fall_edge", d_hs_first, 659);
    chk("a_vsync_width", a_vs_low, 2 * S_HT);
    chk("a_sof_count", a_sof_cnt, 3);

    // Mid-frame reset: outputs must drop before any clock edge.
    @(negedge clk) reset = 1'b1;
    #1 check_reset_state("async");
    repeat (3) begin
      @(posedge clk);
      #1 check_reset_state("hold");
    end
    @(negedge clk) reset = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      check_cycle(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule

`default_nettype wire
